// File: rtl/fir_frame_packer.sv
// Packs {chB, chA} sample pairs into PSAMPLES-deep frames for a decimating FIR, double-buffered.
// Define FIR_FRAME_PACKER_FLUSH_EN to add a flush input that zero-pads and emits a partial frame.
module fir_frame_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int PSAMPLES   = 8,
  parameter int CHANNELS   = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    s_tvalid,
  output logic                                    s_tready,
  input  logic [2*DATA_WIDTH-1:0]                 s_tdata,
`ifdef FIR_FRAME_PACKER_FLUSH_EN
  input  logic                                    flush,
`endif
  output logic                                    m_tvalid,
  input  logic                                    m_tready,
  output logic [CHANNELS*DATA_WIDTH*PSAMPLES-1:0] m_tdata
);

  localparam int FW = CHANNELS * DATA_WIDTH * PSAMPLES;
  localparam int CW = (PSAMPLES > 1) ? $clog2(PSAMPLES) : 1;

  // Handshake: a pair moves when s_tvalid && s_tready on a rising edge; a frame
  // moves when m_tvalid && m_tready. m_tvalid/m_tdata never change while held.
  typedef enum logic {FILL, STALL} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [FW-1:0] asm_q;
  logic [FW-1:0] out_q;
  logic          out_valid;
  logic [FW-1:0] asm_wr;
  logic          accept;
  logic          out_free;
  logic          last_lane;
  logic          flush_hit;
  logic          complete;
  int            lane;

  assign s_tready  = (state == FILL) && !rst;
  assign m_tvalid  = out_valid;
  assign m_tdata   = out_q;
  assign accept    = s_tvalid && s_tready;
  assign out_free  = !out_valid || m_tready;
  assign last_lane = (cnt == CW'(PSAMPLES - 1));
  assign lane      = int'(cnt);

`ifdef FIR_FRAME_PACKER_FLUSH_EN
  // An empty assembly buffer has nothing to flush; STALL already holds a full frame.
  assign flush_hit = flush && (state == FILL) && (cnt != '0);
`else
  assign flush_hit = 1'b0;
`endif

  assign complete = (accept && last_lane) || flush_hit;

  // Unfilled lanes of asm_q are always zero (it is cleared on every hand-off),
  // so a flushed partial frame comes out zero-padded with no extra masking.
  always_comb begin
    asm_wr = asm_q;
    if (accept) begin
      asm_wr[lane*DATA_WIDTH +: DATA_WIDTH]              = s_tdata[DATA_WIDTH-1:0];
      asm_wr[(PSAMPLES+lane)*DATA_WIDTH +: DATA_WIDTH]   = s_tdata[2*DATA_WIDTH-1:DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      cnt       <= '0;
      asm_q     <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (complete) begin
            cnt <= '0;
            if (out_free) begin
              out_q     <= asm_wr;
              out_valid <= 1'b1;
              asm_q     <= '0;
            end else begin
              asm_q <= asm_wr;
              state <= STALL;
            end
          end else begin
            asm_q <= asm_wr;
            if (accept) cnt <= cnt + CW'(1);
            if (out_valid && m_tready) out_valid <= 1'b0;
          end
        end
        STALL: begin
          if (out_free) begin
            out_q     <= asm_q;
            out_valid <= 1'b1;
            asm_q     <= '0;
            state     <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_frame_packer.sv
// Randomized scoreboard bench for fir_frame_packer; the reference model builds whole frames
// from queues of accepted pairs. Flush checks are built when FIR_FRAME_PACKER_FLUSH_EN is defined.
module tb_fir_frame_packer;

  localparam int DW = 16;
  localparam int P  = 8;
  localparam int W  = 2 * DW * P;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [2*DW-1:0] s_tdata = '0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [W-1:0]  m_tdata;
`ifdef FIR_FRAME_PACKER_FLUSH_EN
  logic          flush = 1'b0;
`endif

  always #5 clk = ~clk;

  fir_frame_packer #(.DATA_WIDTH(DW), .PSAMPLES(P), .CHANNELS(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
`ifdef FIR_FRAME_PACKER_FLUSH_EN
    .flush    (flush),
`endif
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  got_q[$];
  logic [DW-1:0] pend_a[$];
  logic [DW-1:0] pend_b[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            frames_seen = 0;
  bit            rand_ready = 1'b0;

  task automatic check_vec(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model: a frame is the list of pending pairs laid out by lane, zero beyond the list.
  function automatic logic [W-1:0] build_frame();
    logic [W-1:0] f;
    f = '0;
    for (int k = 0; k < P; k++) begin
      if (k < pend_a.size()) begin
        f[k*DW +: DW]     = pend_a[k];
        f[(P+k)*DW +: DW] = pend_b[k];
      end
    end
    return f;
  endfunction

  task automatic model_emit();
    exp_q.push_back(build_frame());
    pend_a.delete();
    pend_b.delete();
  endtask

  task automatic model_push(input logic [DW-1:0] a, input logic [DW-1:0] b);
    pend_a.push_back(a);
    pend_b.push_back(b);
    if (pend_a.size() == P) model_emit();
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input int budget, output bit acc);
    int waited;
    waited = 0;
    acc = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = {b, a};
    forever begin
      @(negedge clk);
      if (s_tready) break;
      waited++;
      if (waited >= budget) begin
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
    end
    @(posedge clk);
    model_push(a, b);
    acc = 1'b1;
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b);
    bit acc;
    send_pair(a, b, 200, acc);
    check_int("send_accept", int'(acc), 1);
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_drain_timeout: got %0d frames pending expected 0", name, exp_q.size());
    end
    tick(2);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) m_tready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- monitor ----------------
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (prev_hold && !rst) begin
      check_int("hold_valid", int'(m_tvalid), 1);
      check_vec("hold_data", m_tdata, prev_data);
    end
    prev_hold = m_tvalid && !m_tready && !rst;
    prev_data = m_tdata;
    if (!rst && m_tvalid && m_tready) begin
      got_q.push_back(m_tdata);
      frames_seen++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL frame_unexpected: got %h expected none", m_tdata);
      end else begin
        check_vec("frame", m_tdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int base;
    int acc_n;
    bit acc;
    logic [W-1:0] f;
    real r;
    int v;

    rst = 1'b1;
    tick(3);
    @(negedge clk);
    check_int("rst_m_tvalid", int'(m_tvalid), 0);
    check_vec("rst_m_tdata", m_tdata, '0);
    check_int("rst_s_tready", int'(s_tready), 0);
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check_int("s_tready_after_rst", int'(s_tready), 1);
    tick(1);

    // Ramp with sink always ready: two frames, no bubbles, one-cycle latency.
    m_tready = 1'b1;
    got_q.delete();
    base = frames_seen;
    for (int i = 0; i < 16; i++) begin
      send_pair(DW'(i), DW'(16'h100 + i), 1, acc);
      check_int("t1_no_bubble", int'(acc), 1);
      if (i == 6) check_int("t1_no_early_valid", int'(m_tvalid), 0);
      if (i == 7) check_int("t1_latency", int'(m_tvalid), 1);
    end
    wait_drain("t1");
    check_int("t1_frames", frames_seen - base, 2);
    if (got_q.size() > 0) begin
      f = got_q[0];
      check_int("t1_lane0_a", int'(f[0 +: DW]), 0);
      check_int("t1_lane7_a", int'(f[7*DW +: DW]), 7);
      check_int("t1_lane0_b", int'(f[P*DW +: DW]), 16'h100);
    end else begin
      check_int("t1_frame0_present", got_q.size(), 1);
    end

    // Sink blocked: exactly two frames of buffering, then backpressure.
    m_tready = 1'b0;
    base = frames_seen;
    acc_n = 0;
    for (int i = 0; i < 17; i++) begin
      send_pair(DW'($urandom), DW'($urandom), 20, acc);
      if (acc) acc_n++;
    end
    check_int("t2_accepted", acc_n, 16);
    @(negedge clk);
    check_int("t2_s_tready_low", int'(s_tready), 0);
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    @(negedge clk);
    check_int("t2_low_before_drain", int'(s_tready), 0);
    @(negedge clk);
    check_int("t2_ready_after_drain", int'(s_tready), 1);
    tick(1);
    wait_drain("t2");
    check_int("t2_frames", frames_seen - base, 2);

    // Random backpressure and random source gaps.
    rand_ready = 1'b1;
    base = frames_seen;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 2));
      send(DW'($urandom), DW'($urandom));
    end
    wait_drain("t3");
    rand_ready = 1'b0;
    m_tready = 1'b1;
    check_int("t3_frames", frames_seen - base, 125);

    // 1 kHz sine at 100 kHz, 0.8 full scale, identical on both channels.
    base = frames_seen;
    for (int n = 0; n < 1024; n++) begin
      r = 0.8 * 32767.0 * $sin(2.0 * 3.14159265358979 * 1000.0 * n / 100000.0);
      v = int'(r);
      send(DW'(v), DW'(v));
    end
    wait_drain("t4");
    check_int("t4_frames", frames_seen - base, 128);

    // Reset mid-frame discards the partial frame; next pair lands in lane 0.
    for (int i = 0; i < 5; i++) send(DW'($urandom), DW'($urandom));
    rst = 1'b1;
    @(negedge clk);
    check_int("t5_rst_m_tvalid", int'(m_tvalid), 0);
    check_int("t5_rst_s_tready", int'(s_tready), 0);
    pend_a.delete();
    pend_b.delete();
    tick(1);
    rst = 1'b0;
    got_q.delete();
    base = frames_seen;
    for (int i = 0; i < 8; i++) send(DW'(16'hA0 + i), DW'($urandom));
    wait_drain("t5");
    check_int("t5_frames", frames_seen - base, 1);
    if (got_q.size() > 0) begin
      f = got_q[0];
      check_int("t5_lane0", int'(f[0 +: DW]), 16'hA0);
    end else begin
      check_int("t5_frame_present", got_q.size(), 1);
    end

`ifdef FIR_FRAME_PACKER_FLUSH_EN
    // Flush a 3-pair partial frame, then flush an empty buffer.
    got_q.delete();
    base = frames_seen;
    for (int i = 0; i < 3; i++) send(DW'(16'h11 + i), DW'(16'h21 + i));
    flush = 1'b1;
    if (pend_a.size() > 0) model_emit();
    tick(1);
    flush = 1'b0;
    wait_drain("t6");
    check_int("t6_frames", frames_seen - base, 1);
    if (got_q.size() > 0) begin
      f = got_q[0];
      check_int("t6_lane2_a", int'(f[2*DW +: DW]), 16'h13);
      check_int("t6_lane2_b", int'(f[(P+2)*DW +: DW]), 16'h23);
      for (int k = 3; k < P; k++) begin
        check_int("t6_pad_a", int'(f[k*DW +: DW]), 0);
        check_int("t6_pad_b", int'(f[(P+k)*DW +: DW]), 0);
      end
    end else begin
      check_int("t6_frame_present", got_q.size(), 1);
    end
    base = frames_seen;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(6);
    check_int("t6_empty_flush", frames_seen - base, 0);
`endif

    check_int("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_frame_packer.md
FIR_FRAME_PACKER -- requirements
Module: fir_frame_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: bits per sample.
REQ-002 SHALL have parameter PSAMPLES, default 8: samples per channel per frame.
REQ-003 SHALL have parameter CHANNELS, fixed 2: channel A and channel B.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port s_tvalid  input  1  input sample pair valid.
REQ-007 SHALL have port s_tready  output  1  packer can accept a sample pair.
REQ-008 SHALL have port s_tdata  input  2*DATA_WIDTH  {chB, chA}; chA in the low half.
REQ-009 SHALL have port m_tvalid  output  1  packed frame valid; drives the decimating FIR s_tvalid.
REQ-010 SHALL have port m_tready  input  1  FIR accepts the frame.
REQ-011 SHALL have port m_tdata  output  CHANNELS*DATA_WIDTH*PSAMPLES  packed frame, 256 bits at defaults.

Function
REQ-012 SHALL transfer on input when s_tvalid && s_tready, and on output when m_tvalid && m_tready.
REQ-013 SHALL pack lanes as follows: sample k of chA at bits [16k+15:16k]; sample k of chB at bits [128+16k+15:128+16k]; k=0 is the oldest sample.
REQ-014 SHALL use a lane counter 0..PSAMPLES-1 that increments per accepted pair and wraps to 0 after the PSAMPLES-th pair.
REQ-015 SHALL buffer two frames: one assembly register and one output register; m_tdata is driven from the output register.
REQ-016 SHALL implement a state machine with two states: FILL (s_tready=1) and STALL (s_tready=0, assembly complete, output register occupied).
REQ-017 On the PSAMPLES-th accept in FILL: if the output register is empty or drains in the same cycle, the frame SHALL move to the output register, state stays FILL, and the counter goes to 0; otherwise state SHALL go to STALL.
REQ-018 In STALL, on the first cycle the output register is empty or draining, the assembly frame SHALL move to the output register and state SHALL return to FILL.
REQ-019 Latency SHALL be as follows: m_tvalid rises the cycle after the accept that completes a frame.
REQ-020 With m_tready held high, the packer SHALL sustain one pair per cycle with no s_tready bubbles.
REQ-021 m_tdata and m_tvalid SHALL stay stable while m_tvalid && !m_tready.
REQ-022 Frames SHALL be emitted in order; none SHALL be dropped or duplicated.
REQ-023 Sample values SHALL pass through bit-exact, with no sign extension, scaling or saturation.

Reset
REQ-024 While rst is high: m_tvalid=0, m_tdata=0, s_tready=0, lane counter=0, state=FILL, both buffers cleared.
REQ-025 Reset mid-frame or mid-stall SHALL discard all partial and held frames; the first pair after reset SHALL land in lane 0.
REQ-026 s_tready SHALL go to 1 on the first cycle after rst deasserts.

Configuration
REQ-027 Macro FIR_FRAME_PACKER_FLUSH_EN SHALL add input port flush (1 bit, single-cycle pulse).
REQ-028 With the macro defined, flush in FILL with counter>0 SHALL zero the unfilled lanes and complete the frame per REQ-017.
REQ-029 If a pair is accepted in the same cycle as flush, that pair SHALL be written first and the remaining lanes zero-padded.
REQ-030 With the macro defined, flush with counter=0, or flush in STALL, SHALL be ignored.
REQ-031 Without the macro, the flush port and its logic SHALL be absent, and frames complete only on the PSAMPLES-th accept.

Verification
REQ-032 Bench SHALL cover: m_tready=1, 16 pairs chA=i, chB=0x100+i -> two frames; frame0 bits[15:0]=0, bits[127:112]=7, bits[143:128]=0x100; m_tvalid 1 cycle after the 8th accept; s_tready never low.
REQ-033 Bench SHALL cover: m_tready=0, continuous s_tvalid -> exactly 16 pairs accepted, then s_tready=0; raise m_tready -> frames 0,1 emitted in order, s_tready=1 on the cycle after frame 0 drains.
REQ-034 Bench SHALL cover: random m_tready toggling with 50% duty over 1000 pairs -> m_tdata constant during every stall, 125 frames all bit-exact against the scoreboard.
REQ-035 Bench SHALL cover: 1 kHz sine, fs 100 kHz, amplitude 0.8*32767, same on both channels, 1024 pairs -> 128 frames matching the sinusoid packing of the FIR bench.
REQ-036 Bench SHALL cover: 5 pairs, then rst for one cycle, then 8 pairs chA=0xA0+i -> m_tvalid=0 during reset; the single frame output has lane0=0xA0.
REQ-037 Bench SHALL cover, with FIR_FRAME_PACKER_FLUSH_EN: 3 pairs then flush -> frame lanes 0-2 hold data and lanes 3-7 are 0; flush at counter=0 -> no frame.
